dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port: receives the EX/MEM request (byte-lane
//  write enables already shifted by addr[1:0], write data already lane-aligned), services it from
//  an on-chip word array after a programmable wait, returns the raw aligned word for MEM to shift
//  and extend. A req/ack handshake lets a later pipeline revision stall on memory latency.
// PARAMETERS
//  DEPTH_WORDS  1024          words of storage; address index = addr[31:2] - BASE_ADDR[31:2]
//  BASE_ADDR    32'h0000_0000 byte address of word 0 (word aligned)
//  WAIT_CYCLES  0             extra cycles between accept and ack (0..15)
// PORTS
//  clk     in   1   rising-edge clock
//  rstn    in   1   asynchronous active-low reset
//  req     in   1   request valid; sampled only in IDLE
//  wea     in   4   byte-lane write enables; 4'b0000 = read
//  dmtype  in   3   access size, `dm_word/`dm_halfword/`dm_byte(_unsigned) encodings
//  addr    in   32  byte address
//  wdata   in   32  lane-aligned write data; lane k written iff wea[k]
//  busy    out  1   1 in every state except IDLE
//  ack     out  1   one-cycle completion pulse
//  rdata   out  32  full aligned word at addr[31:2] (post-write contents); valid while ack
//  err     out  1   qualifies ack: misaligned or out-of-range; no storage change
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, busy=0, ack=0, err=0, rdata=0, wait counter=0. Array
//   contents are NOT cleared. Reset mid-transaction abandons it; a write not yet committed is lost.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req=1 latches addr/wea/wdata/dmtype; next state WAIT if WAIT_CYCLES>0 else RESP.
//   WAIT: counter loads WAIT_CYCLES-1 on entry, decrements; at 0 -> RESP.
//   RESP: ack=1 for exactly this cycle; then IDLE. req here and in WAIT is ignored (not queued);
//    requester must hold/re-issue req until it sees ack.
//  Latency: accept edge to ack high = 1+WAIT_CYCLES cycles; back-to-back throughput = one
//   transaction per 2+WAIT_CYCLES cycles.
//  Commit: write lanes committed on the edge entering RESP; rdata in RESP is read from the array
//   after that commit (write then read-back, read-modify within the same word is coherent).
//  Error checks on latched request, evaluated at accept: word needs addr[1:0]==0; halfword needs
//   addr[0]==0; index >= DEPTH_WORDS or addr < BASE_ADDR -> out of range. Also err if wea!=0 and
//   wea popcount does not match dmtype size (catches lanes lost when shift overflows 4 bits).
//   On err: no write, rdata=0, ack=1 and err=1 together in RESP.
//  err and rdata are 0 whenever ack=0. Address arithmetic in 32 bits, wraps modulo 2^32 (no trap).
//  wea ignored (treated as read) if dmtype is an unsigned-load encoding and wea!=0 -> err.
// STRUCTURE
//  dm_* size encodings and WDSel values stay in the shared ctrl definitions; add a shared
//   localparam set for responder states (ST_IDLE/ST_WAIT/ST_RESP).
//  One sub-module: dmem_sram_bank -- DEPTH_WORDS x 32 array, 4 byte-lane write enables, synchronous
//   write, combinational read port; responder holds FSM, checks, counter and output registers.
// TESTING
//  1 WAIT_CYCLES=0: write wea=1111 addr=0x10 wdata=0xDEADBEEF -> ack 1 cycle after accept,
//    rdata=0xDEADBEEF, err=0; read addr=0x10 -> rdata=0xDEADBEEF.
//  2 Byte lanes: word 0x20=0x11223344, byte write wea=0100 addr=0x22 wdata=0x00AA0000 ->
//    read 0x20 returns 0x11AA3344.
//  3 Misaligned: halfword addr=0x23 wea=1000 -> ack with err=1, rdata=0, word 0x20 unchanged;
//    word read addr=0x02 -> err=1.
//  4 WAIT_CYCLES=3: read accept at cycle N -> busy N+1..N+4, ack exactly at N+4; req pulses during
//    busy produce no extra ack.
//  5 Range: addr=BASE_ADDR+4*DEPTH_WORDS -> err=1; addr=BASE_ADDR+4*(DEPTH_WORDS-1) -> err=0.
//  6 Reset mid-WAIT (WAIT_CYCLES=3, write 0xCAFEF00D to 0x40 over old 0x12345678): drop rstn at
//    cycle 2 -> busy=ack=0 immediately; after release read 0x40 -> 0x12345678 (write lost).

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared data-memory access encodings, responder FSM states and size helpers.
// Latency: none (definitions only).
// Backpressure: not applicable.
package dmem_responder_pkg;

    // Access-size encodings carried on dmtype from the control unit
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    // Responder FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Number of bytes touched by an access; unknown codes behave as a word
    function automatic logic [2:0] dm_size_bytes(input logic [2:0] dmtype);
        logic [2:0] size;
        case (dmtype)
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: size = 3'd2;
            DM_BYTE, DM_BYTE_UNSIGNED:         size = 3'd1;
            default:                           size = 3'd4;
        endcase
        return size;
    endfunction

    // Unsigned encodings only exist for loads, so pairing them with lanes is illegal
    function automatic logic dm_is_unsigned(input logic [2:0] dmtype);
        return (dmtype == DM_HALFWORD_UNSIGNED) || (dmtype == DM_BYTE_UNSIGNED);
    endfunction

endpackage

// File: rtl/dmem_responder_sram_bank.sv
// Word array with four byte-lane write enables, synchronous write, combinational read.
// Latency: write lands on the clock edge; read data follows raddr_i in the same cycle.
// Backpressure: none, a write or read is serviced every cycle.
module dmem_sram_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Per-lane write; contents are deliberately never reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) begin
                mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request in IDLE, optional wait, one-cycle ack with aligned word.
// Latency: accept edge to ack = 1 + WAIT_CYCLES cycles; one transaction per 2 + WAIT_CYCLES cycles.
// Backpressure: busy outside IDLE; req while busy is dropped, requester holds req until ack.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [3:0]  wea,
    input  logic [2:0]  dmtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [3:0]    wea_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic          accept;
    logic          enter_resp;
    logic [29:0]   word_off;
    logic [2:0]    size_b;
    logic          out_of_range;
    logic          misaligned;
    logic          lane_err;
    logic          req_err;

    logic [3:0]    bank_we;
    logic [AW-1:0] bank_waddr;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;

    // Legality of the incoming request; only consumed on the accept edge
    always_comb begin
        word_off     = addr[31:2] - BASE_ADDR[31:2];
        size_b       = dm_size_bytes(dmtype);
        out_of_range = (addr < BASE_ADDR) || ({2'b00, word_off} >= DEPTH_WORDS);
        misaligned   = ((size_b == 3'd4) && (addr[1:0] != 2'b00)) ||
                       ((size_b == 3'd2) && addr[0]);
        // A lane count that disagrees with the size means the pre-shift overflowed
        lane_err     = (wea != 4'b0000) &&
                       (dm_is_unsigned(dmtype) || (3'($countones(wea)) != size_b));
        req_err      = out_of_range | misaligned | lane_err;
    end

    // FSM state and wait counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: IDLE -> (WAIT) -> RESP -> IDLE, req outside IDLE is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept     = (state_q == ST_IDLE) && req;
    assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);

    // Latch the request and its verdict at accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q   <= '0;
            wea_q   <= 4'b0000;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= word_off[AW-1:0];
            wea_q   <= wea;
            wdata_q <= wdata;
            err_q   <= req_err;
        end
    end

    // Commit on the edge entering RESP; with no wait that edge is the accept edge,
    // so the live request is used before it has been latched
    always_comb begin
        if (state_q == ST_IDLE) begin
            bank_waddr = word_off[AW-1:0];
            bank_wdata = wdata;
            bank_we    = req_err ? 4'b0000 : wea;
        end else begin
            bank_waddr = idx_q;
            bank_wdata = wdata_q;
            bank_we    = err_q ? 4'b0000 : wea_q;
        end
        if (!enter_resp) begin
            bank_we = 4'b0000;
        end
    end

    dmem_sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk    (clk),
        .we_i   (bank_we),
        .waddr_i(bank_waddr),
        .wdata_i(bank_wdata),
        .raddr_i(idx_q),
        .rdata_o(bank_rdata)
    );

    // Outputs decoded from state; RESP reads the array after the commit edge
    always_comb begin
        busy  = (state_q != ST_IDLE);
        ack   = (state_q == ST_RESP);
        err   = ack && err_q;
        rdata = (ack && !err_q) ? bank_rdata : 32'h0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (no wait / 3-cycle wait, offset base),
// a cycle-level reference model with scoreboard memory, and directed vectors.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        rstn   [2];
    logic        req    [2];
    logic [3:0]  wea    [2];
    logic [2:0]  dmtype [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        busy   [2];
    logic        ack    [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rstn(rstn[0]), .req(req[0]), .wea(wea[0]), .dmtype(dmtype[0]),
        .addr(addr[0]), .wdata(wdata[0]), .busy(busy[0]), .ack(ack[0]),
        .rdata(rdata[0]), .err(err[0]));

    dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rstn(rstn[1]), .req(req[1]), .wea(wea[1]), .dmtype(dmtype[1]),
        .addr(addr[1]), .wdata(wdata[1]), .busy(busy[1]), .ack(ack[1]),
        .rdata(rdata[1]), .err(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction
    function automatic int depth_of(input int d);
        return (d == 1) ? 64 : 1024;
    endfunction
    function automatic int wait_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem [logic [63:0]];
    bit          m_active [2];
    int          m_t      [2];
    int          m_ack_at [2];
    logic [31:0] m_addr   [2];
    logic [3:0]  m_wea    [2];
    logic [31:0] m_wdata  [2];
    bit          m_err    [2];
    logic [31:0] m_rdata  [2];
    bit          m_known  [2];

    function automatic bit model_err(input int d, input logic [3:0] w, input logic [2:0] t,
                                     input logic [31:0] a);
        int sz;
        bit uns;
        case (t)
            3'd1, 3'd2: sz = 2;
            3'd3, 3'd4: sz = 1;
            default:    sz = 4;
        endcase
        uns = (t == 3'd2) || (t == 3'd4);
        if (sz == 4 && a[1:0] != 2'b00) return 1'b1;
        if (sz == 2 && a[0]) return 1'b1;
        if (a < base_of(d)) return 1'b1;
        if (((a - base_of(d)) >> 2) >= 32'(depth_of(d))) return 1'b1;
        if (w != 4'b0000 && (uns || $countones(w) != sz)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] mkey(input int d, input logic [31:0] a);
        return {32'(d), 2'b00, a[31:2]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_model
        always @(posedge clk or negedge rstn[g]) begin
            logic [63:0] key;
            logic [31:0] word;
            bit known;
            if (!rstn[g]) begin
                m_active[g] = 1'b0;
            end else begin
                m_t[g]++;
                if (m_active[g] && m_t[g] > m_ack_at[g]) begin
                    m_active[g] = 1'b0;
                end else if (!m_active[g] && req[g]) begin
                    m_active[g] = 1'b1;
                    m_ack_at[g] = m_t[g] + wait_of(g);
                    m_addr[g]   = addr[g];
                    m_wea[g]    = wea[g];
                    m_wdata[g]  = wdata[g];
                    m_err[g]    = model_err(g, wea[g], dmtype[g], addr[g]);
                end
                if (m_active[g] && m_t[g] == m_ack_at[g]) begin
                    if (m_err[g]) begin
                        m_rdata[g] = 32'h0;
                        m_known[g] = 1'b1;
                    end else begin
                        key   = mkey(g, m_addr[g]);
                        known = mem.exists(key) || (m_wea[g] == 4'hF);
                        word  = mem.exists(key) ? mem[key] : 32'h0;
                        for (int k = 0; k < 4; k++)
                            if (m_wea[g][k]) word[8*k +: 8] = m_wdata[g][8*k +: 8];
                        if (m_wea[g] != 4'b0000 && known) mem[key] = word;
                        m_rdata[g] = word;
                        m_known[g] = known;
                    end
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                bit eack;
                eack = m_active[g] && (m_t[g] == m_ack_at[g]);
                chk($sformatf("model_busy%0d", g), 32'(busy[g]), 32'(m_active[g]));
                chk($sformatf("model_ack%0d", g), 32'(ack[g]), 32'(eack));
                chk($sformatf("model_err%0d", g), 32'(err[g]), 32'(eack && m_err[g]));
                if (!eack || m_known[g])
                    chk($sformatf("model_rdata%0d", g), rdata[g], eack ? m_rdata[g] : 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input int d, input logic [3:0] w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat);
        bit got;
        int n;
        @(negedge clk);
        req[d] = 1'b1; wea[d] = w; dmtype[d] = t; addr[d] = a; wdata[d] = wd;
        got = 1'b0; rd = 32'h0; e = 1'b0;
        for (n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ack[d]) begin
                got = 1'b1;
                rd  = rdata[d];
                e   = err[d];
            end
        end
        lat = n;
        req[d] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout dut%0d addr 0x%08h: no ack within 40 cycles", d, a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic e;
        int lat;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wea[d] = 4'b0; dmtype[d] = DM_WORD; addr[d] = 32'h0; wdata[d] = 32'h0;
            rstn[d] = 1'b1;
        end
        #3;
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        #4;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 32'(busy[d]), 32'h0);
            chk("rst_ack", 32'(ack[d]), 32'h0);
            chk("rst_err", 32'(err[d]), 32'h0);
            chk("rst_rdata", rdata[d], 32'h0);
        end
        @(negedge clk); @(negedge clk);
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // Word write then read-back, no wait
        txn(0, 4'hF, DM_WORD, 32'h10, 32'hDEADBEEF, rd, e, lat);
        chk("t1_wr_rdata", rd, 32'hDEADBEEF);
        chk("t1_wr_err", 32'(e), 32'h0);
        chk("t1_latency", 32'(lat), 32'd1);
        txn(0, 4'h0, DM_WORD, 32'h10, 32'h0, rd, e, lat);
        chk("t1_rd_rdata", rd, 32'hDEADBEEF);

        // Byte lane write inside a word
        txn(0, 4'hF, DM_WORD, 32'h20, 32'h11223344, rd, e, lat);
        txn(0, 4'b0100, DM_BYTE, 32'h22, 32'h00AA0000, rd, e, lat);
        chk("t2_bw_rdata", rd, 32'h11AA3344);
        txn(0, 4'h0, DM_WORD, 32'h20, 32'h0, rd, e, lat);
        chk("t2_rd_rdata", rd, 32'h11AA3344);

        // Misalignment and lane/size mismatch errors leave storage untouched
        txn(0, 4'b1000, DM_HALFWORD, 32'h23, 32'hBB000000, rd, e, lat);
        chk("t3_mis_err", 32'(e), 32'h1);
        chk("t3_mis_rdata", rd, 32'h0);
        txn(0, 4'b0001, DM_BYTE_UNSIGNED, 32'h20, 32'h000000FF, rd, e, lat);
        chk("t3_uns_err", 32'(e), 32'h1);
        txn(0, 4'b0011, DM_BYTE, 32'h20, 32'h0000FFFF, rd, e, lat);
        chk("t3_pop_err", 32'(e), 32'h1);
        txn(0, 4'h0, DM_WORD, 32'h20, 32'h0, rd, e, lat);
        chk("t3_unchanged", rd, 32'h11AA3344);
        txn(0, 4'h0, DM_WORD, 32'h02, 32'h0, rd, e, lat);
        chk("t3_word_mis_err", 32'(e), 32'h1);
        txn(0, 4'b1100, DM_HALFWORD, 32'h22, 32'hBEEF0000, rd, e, lat);
        chk("t3_hw_rdata", rd, 32'hBEEF3344);
        chk("t3_hw_err", 32'(e), 32'h0);

        // Range limits
        txn(0, 4'hF, DM_WORD, 32'h1000, 32'h01010101, rd, e, lat);
        chk("t5_over_err", 32'(e), 32'h1);
        txn(0, 4'hF, DM_WORD, 32'hFFC, 32'h0BADCAFE, rd, e, lat);
        chk("t5_last_err", 32'(e), 32'h0);
        chk("t5_last_rdata", rd, 32'h0BADCAFE);
        txn(1, 4'h0, DM_WORD, 32'hFC, 32'h0, rd, e, lat);
        chk("t5_below_base_err", 32'(e), 32'h1);
        txn(1, 4'hF, DM_WORD, 32'h200, 32'h0, rd, e, lat);
        chk("t5_over1_err", 32'(e), 32'h1);
        txn(1, 4'hF, DM_WORD, 32'h1FC, 32'hA5A5A5A5, rd, e, lat);
        chk("t5_last1_err", 32'(e), 32'h0);

        // Three wait cycles: latency, busy window, ignored req pulses
        txn(1, 4'hF, DM_WORD, 32'h140, 32'h12345678, rd, e, lat);
        chk("t4_wr_latency", 32'(lat), 32'd4);
        chk("t4_wr_rdata", rd, 32'h12345678);
        @(negedge clk);
        req[1] = 1'b1; wea[1] = 4'h0; dmtype[1] = DM_WORD; addr[1] = 32'h140;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("t4_busy_k%0d", k), 32'(busy[1]), 32'(k <= 4));
            chk($sformatf("t4_ack_k%0d", k), 32'(ack[1]), 32'(k == 4));
            if (k == 4) chk("t4_rdata", rdata[1], 32'h12345678);
            req[1] = (k == 2) || (k == 3);
        end

        // Reset during WAIT discards the pending write
        @(negedge clk);
        req[1] = 1'b1; wea[1] = 4'hF; dmtype[1] = DM_WORD; addr[1] = 32'h140; wdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        #2 rstn[1] = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy[1]), 32'h0);
        chk("t6_rst_ack", 32'(ack[1]), 32'h0);
        @(negedge clk); @(negedge clk);
        rstn[1] = 1'b1;
        txn(1, 4'h0, DM_WORD, 32'h140, 32'h0, rd, e, lat);
        chk("t6_write_lost", rd, 32'h12345678);
        chk("t6_rd_err", 32'(e), 32'h0);

        @(negedge clk); @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
